// File: rtl/linreg_pkg.sv
// Shared types, width derivations and saturation limits for the linear-regression datapath.
package linreg_pkg;

  // Width of the wide constants used for saturation limits
  localparam int SAT_LIM_W = 128;

  // Prediction pipeline states
  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RND,
    OUT
  } state_e;

  // Ceiling log2, minimum result 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Accumulator width: full product plus headroom for N_FEAT+1 terms
  function automatic int accWidth(input int dataW, input int nFeat);
    return 2 * dataW + clog2(nFeat + 1);
  endfunction

  // Largest value representable in a signed outW-bit word
  function automatic logic signed [SAT_LIM_W-1:0] satMax(input int outW);
    logic signed [SAT_LIM_W-1:0] one;
    one = 1;
    return (one <<< (outW - 1)) - one;
  endfunction

  // Smallest value representable in a signed outW-bit word
  function automatic logic signed [SAT_LIM_W-1:0] satMin(input int outW);
    logic signed [SAT_LIM_W-1:0] one;
    one = 1;
    return -(one <<< (outW - 1));
  endfunction

endpackage

// File: rtl/linreg_round_sat.sv
// Round-half-up and saturate a wide fixed-point accumulator down to a signed OUT_W word.
module linreg_round_sat
  import linreg_pkg::*;
#(
  parameter int ACC_W  = 67,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [OUT_W-1:0] value_o,
  output logic                    sat_o
);

  // One extra bit so adding the rounding constant can never wrap
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF  = RW'((128'd1 << FRAC_W) >> 1);
  localparam logic signed [RW-1:0] MAX_V = RW'(satMax(OUT_W));
  localparam logic signed [RW-1:0] MIN_V = RW'(satMin(OUT_W));

  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;

  // Bias by one half LSB, drop the fraction, then clip to the output range
  always_comb begin
    biased  = RW'(acc_i) + HALF;
    shifted = biased >>> FRAC_W;
    value_o = shifted[OUT_W-1:0];
    sat_o   = 1'b0;
    if (shifted > MAX_V) begin
      value_o = MAX_V[OUT_W-1:0];
      sat_o   = 1'b1;
    end else if (shifted < MIN_V) begin
      value_o = MIN_V[OUT_W-1:0];
      sat_o   = 1'b1;
    end
  end

endmodule

// File: rtl/linear_regression_predictor_mv.sv
// Multi-feature fixed-point linear-regression predictor with a single serial MAC,
// double-buffered coefficients and a backpressured output register.
module linear_regression_predictor_mv
  import linreg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int N_FEAT = 4,
  parameter int OUT_W  = 32
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_coef_wr,
  input  logic [clog2(N_FEAT+1)-1:0]       i_coef_addr,
  input  logic [DATA_W-1:0]                i_coef_data,
  input  logic                             i_coef_commit,
  output logic                             o_coef_pend,
  input  logic                             i_x_vld,
  input  logic [DATA_W-1:0]                i_x_data,
  input  logic                             i_x_last,
  output logic                             o_x_rdy,
  output logic                             o_pred_vld,
  output logic [OUT_W-1:0]                 o_pred,
  output logic                             o_pred_sat,
  input  logic                             i_pred_rdy,
  output logic                             o_frame_err
);

  localparam int ADDR_W = clog2(N_FEAT + 1);
  localparam int ACC_W  = accWidth(DATA_W, N_FEAT);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N_FEAT - 1);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] coefShadow_q [N_FEAT+1];
  logic signed [DATA_W-1:0] coefShadow_d [N_FEAT+1];
  logic signed [DATA_W-1:0] coefActive_q [N_FEAT+1];
  logic signed [DATA_W-1:0] coefActive_d [N_FEAT+1];
  logic                     pending_q, pending_d;
  logic [OUT_W-1:0]         pred_q, pred_d;
  logic                     predSat_q, predSat_d;
  logic                     frameErr_q, frameErr_d;

  logic                     accept;
  logic                     lastBeat;
  logic                     applyCommit;
  logic signed [DATA_W-1:0] coefSel;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]  theta0Ext;
  logic signed [ACC_W-1:0]  accBase;
  logic [OUT_W-1:0]         rsValue;
  logic                     rsSat;

  assign o_x_rdy     = (state_q == IDLE) || (state_q == ACC);
  assign accept      = i_x_vld && o_x_rdy;
  assign lastBeat    = (count_q == LAST_CNT);
  assign o_pred_vld  = (state_q == OUT);
  assign o_pred      = pred_q;
  assign o_pred_sat  = predSat_q;
  assign o_coef_pend = pending_q;
  assign o_frame_err = frameErr_q;

  linreg_round_sat #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W),
    .OUT_W  (OUT_W)
  ) u_round_sat (
    .acc_i   (acc_q),
    .value_o (rsValue),
    .sat_o   (rsSat)
  );

  // Pick theta_k for the current beat, form the product and the sample's starting accumulator
  always_comb begin
    coefSel = coefActive_q[1];
    for (int k = 1; k <= N_FEAT; k++) begin
      if (count_q == ADDR_W'(k - 1)) coefSel = coefActive_q[k];
    end
    product   = (2*DATA_W)'(coefSel) * (2*DATA_W)'($signed(i_x_data));
    theta0Ext = ACC_W'(coefActive_q[0]);
    accBase   = (state_q == IDLE) ? (theta0Ext <<< FRAC_W) : acc_q;
  end

  // Next-state logic for the sample FSM, MAC, output register and framing check
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = accBase;
    pred_d     = pred_q;
    predSat_d  = predSat_q;
    frameErr_d = 1'b0;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d      = accBase + ACC_W'(product);
          frameErr_d = (i_x_last != lastBeat);
          if (lastBeat) begin
            state_d = RND;
            count_d = '0;
          end else begin
            state_d = ACC;
            count_d = count_q + 1'b1;
          end
        end
      end
      RND: begin
        pred_d    = rsValue;
        predSat_d = rsSat;
        state_d   = OUT;
      end
      OUT: begin
        if (i_pred_rdy) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow writes and the shadow-to-active copy, which only happens between samples
  always_comb begin
    coefShadow_d = coefShadow_q;
    coefActive_d = coefActive_q;
    applyCommit  = (pending_q || i_coef_commit) && (state_q == IDLE) && !accept;
    pending_d    = pending_q || i_coef_commit;
    if (applyCommit) begin
      coefActive_d = coefShadow_q;
      pending_d    = 1'b0;
    end
    if (i_coef_wr) begin
      for (int k = 0; k <= N_FEAT; k++) begin
        if (i_coef_addr == ADDR_W'(k)) coefShadow_d[k] = i_coef_data;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      pred_q     <= '0;
      predSat_q  <= 1'b0;
      frameErr_q <= 1'b0;
      for (int k = 0; k <= N_FEAT; k++) begin
        coefShadow_q[k] <= '0;
        coefActive_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      pending_q    <= pending_d;
      pred_q       <= pred_d;
      predSat_q    <= predSat_d;
      frameErr_q   <= frameErr_d;
      coefShadow_q <= coefShadow_d;
      coefActive_q <= coefActive_d;
    end
  end

endmodule

// File: tb/tb_linear_regression_predictor_mv.sv
// Scoreboard bench for linear_regression_predictor_mv with N_FEAT=2, Q16.16 data.
module tb_linear_regression_predictor_mv;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int NF     = 2;
  localparam int OUT_W  = 32;

  logic              i_clock;
  logic              i_reset;
  logic              i_coef_wr;
  logic [1:0]        i_coef_addr;
  logic [DATA_W-1:0] i_coef_data;
  logic              i_coef_commit;
  logic              o_coef_pend;
  logic              i_x_vld;
  logic [DATA_W-1:0] i_x_data;
  logic              i_x_last;
  logic              o_x_rdy;
  logic              o_pred_vld;
  logic [OUT_W-1:0]  o_pred;
  logic              o_pred_sat;
  logic              i_pred_rdy;
  logic              o_frame_err;

  linear_regression_predictor_mv #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .N_FEAT (NF),
    .OUT_W  (OUT_W)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_coef_wr     (i_coef_wr),
    .i_coef_addr   (i_coef_addr),
    .i_coef_data   (i_coef_data),
    .i_coef_commit (i_coef_commit),
    .o_coef_pend   (o_coef_pend),
    .i_x_vld       (i_x_vld),
    .i_x_data      (i_x_data),
    .i_x_last      (i_x_last),
    .o_x_rdy       (o_x_rdy),
    .o_pred_vld    (o_pred_vld),
    .o_pred        (o_pred),
    .o_pred_sat    (o_pred_sat),
    .i_pred_rdy    (i_pred_rdy),
    .o_frame_err   (o_frame_err)
  );

  typedef struct packed {
    logic [31:0] pred;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int frameErrSeen = 0;
  int frameErrExp = 0;
  int rdyMode = 0;
  logic signed [31:0] tbShadow [NF+1];
  logic signed [31:0] tbActive [NF+1];
  logic signed [31:0] sampleX [NF];
  logic [31:0] heldPred;
  logic heldSat;
  bit holding = 0;

  // Free-running clock
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic signed [127:0] sx(input logic signed [31:0] v);
    return $signed({{96{v[31]}}, v});
  endfunction

  // Reference: exact sum in 128 bits, floor((acc + half)/2^16), clip to signed 32
  function automatic exp_t modelPredict();
    logic signed [127:0] acc;
    logic signed [127:0] q;
    exp_t e;
    acc = sx(tbActive[0]) * (2 ** FRAC_W);
    for (int k = 1; k <= NF; k++) acc = acc + sx(tbActive[k]) * sx(sampleX[k-1]);
    q = (acc + 32768) >>> FRAC_W;
    if (q > 128'sd2147483647) begin
      e.pred = 32'h7FFFFFFF;
      e.sat  = 1'b1;
    end else if (q < -128'sd2147483648) begin
      e.pred = 32'h80000000;
      e.sat  = 1'b1;
    end else begin
      e.pred = q[31:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] randVal();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return $urandom_range(0, 32'h000FFFFF) - 32'h00080000;
  endfunction

  // Consumer ready: 0 = always ready, 1 = random, 2 = held off
  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      case (rdyMode)
        0:       i_pred_rdy = 1'b1;
        1:       i_pred_rdy = 1'($urandom % 2);
        default: i_pred_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold stability
  always @(negedge i_clock) begin
    exp_t e;
    if (i_reset) begin
      holding = 0;
    end else begin
      if (o_frame_err) frameErrSeen++;
      if (o_pred_vld) begin
        checkOutput("x_rdy low while pred valid", o_x_rdy, 0);
        if (holding) begin
          checkOutput("pred stable under backpressure", o_pred, heldPred);
          checkOutput("sat stable under backpressure", o_pred_sat, heldSat);
        end
        if (i_pred_rdy) begin
          holding = 0;
          if (sb.size() == 0) begin
            checkOutput("unexpected prediction", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("prediction", o_pred, e.pred);
            checkOutput("saturation flag", o_pred_sat, e.sat);
          end
        end else begin
          holding  = 1;
          heldPred = o_pred;
          heldSat  = o_pred_sat;
        end
      end else begin
        holding = 0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic sendBeat(input logic [31:0] x, input logic last);
    bit accepted;
    int n;
    accepted = 0;
    n = 0;
    i_x_vld  = 1'b1;
    i_x_data = x;
    i_x_last = last;
    while (!accepted && n < 200) begin
      accepted = o_x_rdy;
      tick();
      n++;
    end
    if (!accepted) checkOutput("beat accept timeout", 0, 1);
    i_x_vld  = 1'b0;
    i_x_last = 1'b0;
    i_x_data = '0;
  endtask

  task automatic pushExpected(input logic [NF-1:0] lastMask);
    sb.push_back(modelPredict());
    for (int b = 0; b < NF; b++) begin
      if (lastMask[b] != (b == NF - 1)) frameErrExp++;
    end
  endtask

  task automatic applyStimulus(input logic [NF-1:0] lastMask, input bit gaps);
    pushExpected(lastMask);
    for (int b = 0; b < NF; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      sendBeat(sampleX[b], lastMask[b]);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_pred_vld) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) checkOutput("drain timeout", 0, 1);
    tick();
  endtask

  task automatic writeCoef(input logic [1:0] addr, input logic [31:0] data);
    i_coef_wr   = 1'b1;
    i_coef_addr = addr;
    i_coef_data = data;
    tick();
    i_coef_wr = 1'b0;
    if (int'(addr) <= NF) tbShadow[addr] = data;
  endtask

  task automatic commitIdle();
    drain();
    i_coef_commit = 1'b1;
    tick();
    i_coef_commit = 1'b0;
    tick();
    tick();
    checkOutput("pending cleared in idle", o_coef_pend, 0);
    tbActive = tbShadow;
  endtask

  task automatic setCoefs(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    writeCoef(2'd0, t0);
    writeCoef(2'd1, t1);
    writeCoef(2'd2, t2);
    commitIdle();
  endtask

  initial begin
    int n;
    i_reset = 1'b1;
    i_coef_wr = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    i_coef_commit = 1'b0;
    i_x_vld = 1'b0;
    i_x_data = '0;
    i_x_last = 1'b0;
    i_pred_rdy = 1'b1;
    for (int k = 0; k <= NF; k++) begin
      tbShadow[k] = '0;
      tbActive[k] = '0;
    end
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    checkOutput("reset pred_vld", o_pred_vld, 0);
    checkOutput("reset x_rdy", o_x_rdy, 1);
    checkOutput("reset pred", o_pred, 0);
    checkOutput("reset pred_sat", o_pred_sat, 0);
    checkOutput("reset frame_err", o_frame_err, 0);
    checkOutput("reset coef_pend", o_coef_pend, 0);

    $display("[TB] basic prediction and latency");
    setCoefs(32'h00010000, 32'h00020000, 32'hFFFF8000);
    sampleX[0] = 32'h00030000;
    sampleX[1] = 32'h00040000;
    applyStimulus(2'b10, 0);
    checkOutput("pred_vld low one cycle after last beat", o_pred_vld, 0);
    tick();
    checkOutput("pred_vld high two edges after last beat", o_pred_vld, 1);
    drain();
    checkOutput("frame_err count basic", frameErrSeen, frameErrExp);

    $display("[TB] rounding");
    setCoefs(32'h0, 32'h00008000, 32'h0);
    sampleX[0] = 32'h00000001;
    sampleX[1] = 32'h0;
    applyStimulus(2'b10, 0);
    sampleX[0] = 32'hFFFFFFFF;
    applyStimulus(2'b10, 0);
    sampleX[0] = 32'h00000003;
    applyStimulus(2'b10, 0);

    $display("[TB] saturation");
    setCoefs(32'h0, 32'h7FFF0000, 32'h7FFF0000);
    sampleX[0] = 32'h7FFF0000;
    sampleX[1] = 32'h7FFF0000;
    applyStimulus(2'b10, 0);
    setCoefs(32'h0, 32'h80010000, 32'h80010000);
    applyStimulus(2'b10, 0);

    $display("[TB] backpressure and gaps");
    setCoefs(32'h00010000, 32'h00020000, 32'hFFFF8000);
    rdyMode = 2;
    tick();
    sampleX[0] = 32'h00030000;
    sampleX[1] = 32'h00040000;
    applyStimulus(2'b10, 0);
    n = 0;
    while (!o_pred_vld && n < 20) begin
      tick();
      n++;
    end
    repeat (5) tick();
    checkOutput("pred held valid under backpressure", o_pred_vld, 1);
    checkOutput("x_rdy low under backpressure", o_x_rdy, 0);
    rdyMode = 0;
    drain();
    applyStimulus(2'b10, 1);
    applyStimulus(2'b10, 1);
    drain();

    $display("[TB] commit mid-sample");
    pushExpected(2'b10);
    sendBeat(sampleX[0], 1'b0);
    writeCoef(2'd1, 32'h00050000);
    i_coef_commit = 1'b1;
    tick();
    i_coef_commit = 1'b0;
    checkOutput("pending set mid-sample", o_coef_pend, 1);
    sendBeat(sampleX[1], 1'b1);
    checkOutput("pending held after last beat", o_coef_pend, 1);
    drain();
    checkOutput("pending cleared after sample", o_coef_pend, 0);
    tbActive = tbShadow;
    applyStimulus(2'b10, 0);
    drain();

    $display("[TB] framing");
    applyStimulus(2'b11, 0);
    drain();
    checkOutput("frame_err early last", frameErrSeen, frameErrExp);
    applyStimulus(2'b00, 0);
    drain();
    checkOutput("frame_err missing last", frameErrSeen, frameErrExp);

    $display("[TB] reset mid-sample");
    writeCoef(2'd0, 32'h00070000);
    sendBeat(32'h00010000, 1'b0);
    i_coef_commit = 1'b1;
    tick();
    i_coef_commit = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checkOutput("post-reset pred_vld", o_pred_vld, 0);
    checkOutput("post-reset x_rdy", o_x_rdy, 1);
    checkOutput("post-reset coef_pend", o_coef_pend, 0);
    for (int k = 0; k <= NF; k++) begin
      tbShadow[k] = '0;
      tbActive[k] = '0;
    end
    commitIdle();
    sampleX[0] = 32'h00030000;
    sampleX[1] = 32'h00040000;
    applyStimulus(2'b10, 0);
    drain();

    $display("[TB] randomized samples");
    rdyMode = 1;
    for (int s = 0; s < 30; s++) begin
      if (s % 6 == 0) begin
        writeCoef(2'd3, randVal());
        setCoefs(randVal(), randVal(), randVal());
      end
      sampleX[0] = randVal();
      sampleX[1] = randVal();
      applyStimulus(2'b10, 1'($urandom % 2));
    end
    drain();
    rdyMode = 0;
    drain();
    checkOutput("frame_err total", frameErrSeen, frameErrExp);
    checkOutput("scoreboard empty", sb.size(), 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/linear_regression_predictor_mv.md
Name: linear_regression_predictor_mv

Overview:
Multi-feature fixed-point linear-regression predictor: y = theta0 + sum(theta_k * x_k), k = 1..N_FEAT.
- Features stream in serially, one per beat, over a valid/ready handshake; they are accumulated by a single MAC.
- The result is rounded and saturated, then held in an output register with backpressure.
- Coefficients are double-buffered (shadow/active) and written by the training block; predictions always use one consistent coefficient set.

Parameters:
DATA_W, 32, width of features and coefficients (signed two's complement)
FRAC_W, 16, fractional bits of features, coefficients and output (Q(DATA_W-FRAC_W).FRAC_W)
N_FEAT, 4, features per sample (>=1)
OUT_W, 32, prediction width (same FRAC_W)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_coef_wr  in  1  write shadow coefficient
i_coef_addr  in  clog2(N_FEAT+1)  0=theta0, k=theta_k; addr>N_FEAT ignored
i_coef_data  in  DATA_W  coefficient value
i_coef_commit  in  1  request shadow->active copy
o_coef_pend  out  1  commit requested, not yet applied
i_x_vld  in  1  feature beat valid
i_x_data  in  DATA_W  feature value
i_x_last  in  1  source marks final feature of sample
o_x_rdy  out  1  feature beat accepted when i_x_vld&o_x_rdy
o_pred_vld  out  1  prediction valid
o_pred  out  OUT_W  prediction
o_pred_sat  out  1  o_pred was saturated (qualified by o_pred_vld)
i_pred_rdy  in  1  consumer ready
o_frame_err  out  1  one-cycle pulse: i_x_last misaligned with beat count

Behaviour:
- Reset (i_reset=1 at a clock edge): state IDLE, beat count 0, acc 0, both coefficient banks 0, pending 0; all outputs 0 except o_x_rdy. The reset aborts any in-flight sample and discards any held prediction.
- States:
  - IDLE: o_x_rdy=1; acc holds active theta0<<FRAC_W. An accepted beat enters ACC, or RND if N_FEAT=1.
  - ACC: o_x_rdy=1; each accepted beat k does acc += theta_k*x_k and count++. The beat with count==N_FEAT-1 moves to RND.
  - RND: o_x_rdy=0; load o_pred, o_pred_sat; go to OUT.
  - OUT: o_x_rdy=0, o_pred_vld=1. When i_pred_rdy=1: go to IDLE, reload acc, count=0.
- Latency: last beat accepted at edge t -> o_pred_vld=1 from cycle after edge t+1. Throughput is one sample per N_FEAT+2 cycles with no stall.
- Handshake:
  - o_pred and o_pred_sat are stable while o_pred_vld=1 and i_pred_rdy=0.
  - i_x_vld gaps are allowed; count advances only on acceptance.
- Arithmetic:
  - Product is 2*DATA_W signed. Accumulator is 2*DATA_W+clog2(N_FEAT+1) bits, no internal overflow.
  - Theta0 is sign-extended and shifted left FRAC_W.
  - Result = (acc + 2^(FRAC_W-1)) >>> FRAC_W (round half up, arithmetic shift).
  - The result is saturated to signed OUT_W: max 2^(OUT_W-1)-1, min -2^(OUT_W-1). o_pred_sat=1 when clipped.
- Framing:
  - Framing is governed by the beat counter.
  - i_x_last=1 on a beat other than N_FEAT-1, or i_x_last=0 on beat N_FEAT-1, pulses o_frame_err the cycle after acceptance. The sample still completes normally.
- Coefficients:
  - i_coef_wr writes the shadow bank in any state.
  - i_coef_commit sets pending.
  - Pending is applied (shadow->active, pending cleared) on any edge where the state is IDLE and no beat is accepted.
  - An IDLE acceptance with pending set defers the copy until the next return to IDLE.
  - A sample therefore never mixes coefficient sets.
  - Commit simultaneous with wr in the same cycle copies the pre-write shadow; the new write lands in shadow only.
  - o_coef_pend mirrors pending.

Decomposition:
- Package linreg_pkg:
  - clog2 function
  - state enum (IDLE, ACC, RND, OUT)
  - ACC_W derivation
  - saturation limit constants helper
- Sub-module linreg_round_sat (combinational: acc, FRAC_W, OUT_W -> value, sat flag), reused by the training block's output stage.

Test Plan:
- Basic, N_FEAT=2, FRAC_W=16:
  - theta0=0x00010000, theta1=0x00020000, theta2=0xFFFF8000, commit.
  - x=0x00030000, 0x00040000 with last on beat 2 -> o_pred=0x00050000, sat=0, frame_err never.
- Rounding: theta0=0, theta1=0x00008000, theta2=0; x=0x00000001, 0 -> o_pred=0x00000001.
- Saturation:
  - theta1=theta2=0x7FFF0000, x=0x7FFF0000 twice -> o_pred=0x7FFFFFFF, sat=1.
  - Negate theta1 and theta2 -> o_pred=0x80000000, sat=1.
- Backpressure/gaps:
  - Hold i_pred_rdy=0 for 5 cycles -> o_pred stable, o_x_rdy=0.
  - i_x_vld toggling -> same result as the gap-free run.
- Commit mid-sample:
  - Write theta1=0x00050000 and commit after beat 1 -> current sample uses the old set, o_coef_pend=1 until IDLE.
  - Next sample uses the new set.
- Framing/reset:
  - i_x_last on beat 1 of 2 -> one o_frame_err pulse, result still correct.
  - i_reset asserted in ACC -> next cycle IDLE, o_pred_vld=0, coefficients 0.
